// File: rtl/ni_credit_tx_pkg.sv
// rtl/ni_credit_tx_pkg.sv - shared defaults, channel ids and clog2 helper for the NI transmit stage
package ni_credit_tx_pkg;

    localparam int NI_DATA_W     = 32;
    localparam int NI_FIFO_DEPTH = 4;

    typedef enum int unsigned {
        NI_CH_ACT  = 0,
        NI_CH_READ = 1,
        NI_CH_FIN  = 2
    } ni_ch_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ni_credit_tx_if.sv
// rtl/ni_credit_tx_if.sv - source/router-side bundle of the NI transmit stage (master drives sources, slave is the stage)
interface ni_credit_tx_if
    import ni_credit_tx_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = NI_DATA_W,
    parameter int CREDIT_INIT = 4
);

    localparam int CH_W  = clog2(NUM_CH);
    localparam int CNT_W = clog2(CREDIT_INIT + 1);

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_data_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     downstream_credit;
    logic                     router_rdy;
    logic [CNT_W-1:0]         credit_cnt;
    logic                     idle;
    logic                     credit_err;

    modport master (
        output in_valid, in_data, downstream_credit,
        input  in_ready, out_data_valid, out_data, out_ch, router_rdy, credit_cnt, idle, credit_err
    );

    modport slave (
        input  in_valid, in_data, downstream_credit,
        output in_ready, out_data_valid, out_data, out_ch, router_rdy, credit_cnt, idle, credit_err
    );

endinterface

// File: rtl/ni_tx_fifo.sv
// rtl/ni_tx_fifo.sv - per-channel synchronous FIFO with combinational head (push, pop, din, dout, full, empty)
module ni_tx_fifo
    import ni_credit_tx_pkg::*;
#(
    parameter int DATA_W     = NI_DATA_W,
    parameter int FIFO_DEPTH = NI_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // Push is judged against the registered full flag, so a pop in the same cycle does not make room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ni_credit_tx.sv
// rtl/ni_credit_tx.sv - N-channel credit-based NI transmit stage (clk, rst, bus slave modport; option NI_TX_PRIORITY_EN)
module ni_credit_tx
    import ni_credit_tx_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = NI_DATA_W,
    parameter int FIFO_DEPTH  = NI_FIFO_DEPTH,
    parameter int CREDIT_INIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    ni_credit_tx_if.slave bus
);

    localparam int CH_W  = clog2(NUM_CH);
    localparam int CNT_W = clog2(CREDIT_INIT + 1);

    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] pop;
    logic [DATA_W-1:0] head [NUM_CH];

    logic [NUM_CH-1:0] cand;
    logic              hi_hit;
    logic              lo_hit;
    logic [CH_W-1:0]   hi_ch;
    logic [CH_W-1:0]   lo_ch;
    logic              any_req;
    logic              grant;
    logic [CH_W-1:0]   grant_ch;
    logic              adv_ptr;

    logic [CH_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  credit_cnt;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              credit_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ni_tx_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (bus.in_valid[i]),
            .pop   (pop[i]),
            .din   (bus.in_data[i*DATA_W +: DATA_W]),
            .dout  (head[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Round-robin: lowest eligible channel at or above the pointer, else lowest eligible overall (wrap).
    always_comb begin
        cand = ~fifo_empty;
`ifdef NI_TX_PRIORITY_EN
        cand[0] = 1'b0;
`endif
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_ch  = '0;
        lo_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo_hit = 1'b1;
                lo_ch  = CH_W'(i);
            end
            if (cand[i] && (CH_W'(i) >= rr_ptr)) begin
                hi_hit = 1'b1;
                hi_ch  = CH_W'(i);
            end
        end
        grant_ch = hi_hit ? hi_ch : lo_ch;
        any_req  = hi_hit || lo_hit;
        adv_ptr  = 1'b1;
`ifdef NI_TX_PRIORITY_EN
        // Channel 0 pre-empts the rotation and leaves the pointer untouched.
        if (!fifo_empty[0]) begin
            grant_ch = '0;
            any_req  = 1'b1;
            adv_ptr  = 1'b0;
        end
`endif
        // Uses the registered count: a credit returning at zero enables a grant only next cycle.
        grant = any_req && (credit_cnt != '0);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = grant && (grant_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            credit_cnt   <= CNT_W'(CREDIT_INIT);
            credit_err_q <= 1'b0;
        end else begin
            out_valid_q <= grant;
            if (grant) begin
                out_data_q <= head[grant_ch];
                out_ch_q   <= grant_ch;
                if (adv_ptr) begin
                    rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
                end
            end
            case ({grant, bus.downstream_credit})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    // Excess credit saturates the counter and latches an error until reset.
                    if (credit_cnt == CNT_W'(CREDIT_INIT)) begin
                        credit_err_q <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + 1'b1;
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    assign bus.in_ready       = ~fifo_full;
    assign bus.out_data_valid = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_ch         = out_ch_q;
    assign bus.router_rdy     = (credit_cnt != '0);
    assign bus.credit_cnt     = credit_cnt;
    assign bus.credit_err     = credit_err_q;
    assign bus.idle           = (&fifo_empty) && !out_valid_q && (credit_cnt == CNT_W'(CREDIT_INIT));

endmodule

// File: tb/tb_ni_credit_tx.sv
// tb/tb_ni_credit_tx.sv - directed self-checking bench for ni_credit_tx (3 channels, depth 4, 4 credits)
module tb_ni_credit_tx;
    import ni_credit_tx_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    ni_credit_tx_if #(.NUM_CH(3), .DATA_W(32), .CREDIT_INIT(4)) bus ();

    ni_credit_tx #(
        .NUM_CH      (3),
        .DATA_W      (32),
        .FIFO_DEPTH  (4),
        .CREDIT_INIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.downstream_credit = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic push_one(input int ch, input logic [31:0] data);
        bus.in_valid = 3'(1 << ch);
        bus.in_data[ch*32 +: 32] = data;
        step;
        bus.in_valid = '0;
    endtask

    task automatic test_reset;
        do_reset;
        tests_run++;
        if (bus.in_ready !== 3'b111) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 111", bus.in_ready); end
        tests_run++;
        if (bus.out_data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_data_valid); end
        tests_run++;
        if (bus.out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        tests_run++;
        if (bus.out_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_out_ch: got %0d expected 0", bus.out_ch); end
        tests_run++;
        if (bus.credit_cnt !== 3'd4) begin tests_failed++; $display("FAIL reset_credit_cnt: got %0d expected 4", bus.credit_cnt); end
        tests_run++;
        if (bus.router_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_router_rdy: got %b expected 1", bus.router_rdy); end
        tests_run++;
        if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL reset_credit_err: got %b expected 0", bus.credit_err); end
        tests_run++;
        if (bus.idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b expected 1", bus.idle); end
    endtask

    task automatic test_single_push;
        do_reset;
        step;
        push_one(int'(NI_CH_READ), 32'h0000_00A5);
        tests_run++;
        if (bus.out_data_valid !== 1'b0) begin tests_failed++; $display("FAIL single_latency_early: got valid %b expected 0", bus.out_data_valid); end
        tests_run++;
        if (bus.idle !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got idle %b expected 0", bus.idle); end
        step;
        tests_run++;
        if (bus.out_data_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", bus.out_data_valid); end
        tests_run++;
        if (bus.out_data !== 32'h0000_00A5) begin tests_failed++; $display("FAIL single_data: got %h expected 000000a5", bus.out_data); end
        tests_run++;
        if (bus.out_ch !== 2'd1) begin tests_failed++; $display("FAIL single_ch: got %0d expected 1", bus.out_ch); end
        tests_run++;
        if (bus.credit_cnt !== 3'd3) begin tests_failed++; $display("FAIL single_credit: got %0d expected 3", bus.credit_cnt); end
        step;
        tests_run++;
        if (bus.out_data_valid !== 1'b0 || bus.out_data !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL single_pulse_hold: got valid %b data %h expected valid 0 data 000000a5", bus.out_data_valid, bus.out_data);
        end
        bus.downstream_credit = 1'b1;
        step;
        bus.downstream_credit = 1'b0;
        tests_run++;
        if (bus.credit_cnt !== 3'd4 || bus.idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_return: got credit %0d idle %b expected 4 and 1", bus.credit_cnt, bus.idle);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  exp_ch [4];
        logic [31:0] exp_d [4];
`ifdef NI_TX_PRIORITY_EN
        exp_ch = '{2'd0, 2'd0, 2'd1, 2'd2};
        exp_d  = '{32'h10, 32'h11, 32'h20, 32'h30};
`else
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_d  = '{32'h10, 32'h20, 32'h30, 32'h11};
`endif
        do_reset;
        bus.in_valid = 3'b111;
        bus.in_data = {32'h30, 32'h20, 32'h10};
        step;
        bus.in_data = {32'h31, 32'h21, 32'h11};
        step;
        bus.in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (bus.out_data_valid !== 1'b1 || bus.out_ch !== exp_ch[k] || bus.out_data !== exp_d[k]) begin
                tests_failed++;
                $display("FAIL b2b_flit%0d: got valid %b ch %0d data %h expected valid 1 ch %0d data %h",
                         k, bus.out_data_valid, bus.out_ch, bus.out_data, exp_ch[k], exp_d[k]);
            end
            tests_run++;
            if (bus.credit_cnt !== 3'(3 - k)) begin tests_failed++; $display("FAIL b2b_credit%0d: got %0d expected %0d", k, bus.credit_cnt, 3 - k); end
            step;
        end
        tests_run++;
        if (bus.out_data_valid !== 1'b0 || bus.router_rdy !== 1'b0 || bus.credit_cnt !== 3'd0) begin
            tests_failed++;
            $display("FAIL b2b_stall: got valid %b rdy %b credit %0d expected 0 0 0", bus.out_data_valid, bus.router_rdy, bus.credit_cnt);
        end
        step;
        bus.downstream_credit = 1'b1;
        step;
        bus.downstream_credit = 1'b0;
        tests_run++;
        if (bus.out_data_valid !== 1'b0 || bus.credit_cnt !== 3'd1) begin
            tests_failed++;
            $display("FAIL b2b_credit_return: got valid %b credit %0d expected 0 1", bus.out_data_valid, bus.credit_cnt);
        end
        step;
        tests_run++;
        if (bus.out_data_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 32'h21 || bus.credit_cnt !== 3'd0) begin
            tests_failed++;
            $display("FAIL b2b_one_more: got valid %b ch %0d data %h credit %0d expected 1 1 00000021 0",
                     bus.out_data_valid, bus.out_ch, bus.out_data, bus.credit_cnt);
        end
        step;
        tests_run++;
        if (bus.out_data_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_only_one: got valid %b expected 0", bus.out_data_valid); end
    endtask

    task automatic test_fifo_full;
        logic [31:0] got [8];
        int n;
        do_reset;
        for (int k = 0; k < 4; k++) push_one(0, 32'h50 + 32'(k));
        step;
        step;
        step;
        tests_run++;
        if (bus.credit_cnt !== 3'd0 || bus.router_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drain: got credit %0d rdy %b expected 0 0", bus.credit_cnt, bus.router_rdy);
        end
        for (int k = 0; k < 4; k++) push_one(2, 32'hC0 + 32'(k));
        tests_run++;
        if (bus.in_ready !== 3'b011) begin tests_failed++; $display("FAIL full_in_ready: got %b expected 011", bus.in_ready); end
        push_one(2, 32'hFF);
        tests_run++;
        if (bus.in_ready !== 3'b011 || bus.out_data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_overflow_push: got ready %b valid %b expected 011 0", bus.in_ready, bus.out_data_valid);
        end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            bus.downstream_credit = (c < 4);
            step;
            if (bus.out_data_valid === 1'b1) begin
                if (n < 8) got[n] = bus.out_data;
                n++;
            end
        end
        bus.downstream_credit = 1'b0;
        tests_run++;
        if (n != 4) begin tests_failed++; $display("FAIL full_flit_count: got %0d expected 4", n); end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (n > k && got[k] !== 32'hC0 + 32'(k)) begin
                tests_failed++;
                $display("FAIL full_order%0d: got %h expected %h", k, got[k], 32'hC0 + 32'(k));
            end
        end
        tests_run++;
        if (bus.in_ready !== 3'b111 || bus.credit_cnt !== 3'd0) begin
            tests_failed++;
            $display("FAIL full_after: got ready %b credit %0d expected 111 0", bus.in_ready, bus.credit_cnt);
        end
    endtask

    task automatic test_credit_corner;
        do_reset;
        push_one(0, 32'h1);
        push_one(0, 32'h2);
        push_one(0, 32'h3);
        tests_run++;
        if (bus.credit_cnt !== 3'd2) begin tests_failed++; $display("FAIL credit_pre: got %0d expected 2", bus.credit_cnt); end
        bus.downstream_credit = 1'b1;
        step;
        bus.downstream_credit = 1'b0;
        tests_run++;
        if (bus.credit_cnt !== 3'd2 || bus.out_data_valid !== 1'b1 || bus.out_data !== 32'h3) begin
            tests_failed++;
            $display("FAIL credit_simultaneous: got credit %0d valid %b data %h expected 2 1 00000003",
                     bus.credit_cnt, bus.out_data_valid, bus.out_data);
        end
        bus.downstream_credit = 1'b1;
        step;
        step;
        bus.downstream_credit = 1'b0;
        tests_run++;
        if (bus.idle !== 1'b1 || bus.credit_cnt !== 3'd4 || bus.credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL credit_full_idle: got idle %b credit %0d err %b expected 1 4 0", bus.idle, bus.credit_cnt, bus.credit_err);
        end
        bus.downstream_credit = 1'b1;
        step;
        bus.downstream_credit = 1'b0;
        tests_run++;
        if (bus.credit_cnt !== 3'd4 || bus.credit_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL credit_overflow: got credit %0d err %b expected 4 1", bus.credit_cnt, bus.credit_err);
        end
        step;
        step;
        step;
        tests_run++;
        if (bus.credit_err !== 1'b1) begin tests_failed++; $display("FAIL credit_err_sticky: got %b expected 1", bus.credit_err); end
        do_reset;
        tests_run++;
        if (bus.credit_err !== 1'b0) begin tests_failed++; $display("FAIL credit_err_clear: got %b expected 0", bus.credit_err); end
    endtask

    task automatic test_reset_mid;
        int seen;
        do_reset;
        bus.in_valid = 3'b111;
        bus.in_data = {32'h32, 32'h22, 32'h12};
        step;
        bus.in_data = {32'h33, 32'h23, 32'h13};
        step;
        bus.in_valid = '0;
        step;
        step;
        tests_run++;
        if (bus.credit_cnt !== 3'd1) begin tests_failed++; $display("FAIL mid_pre_credit: got %0d expected 1", bus.credit_cnt); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        tests_run++;
        if (bus.idle !== 1'b1 || bus.credit_cnt !== 3'd4 || bus.in_ready !== 3'b111 || bus.out_data_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_state: got idle %b credit %0d ready %b valid %b data %h expected 1 4 111 0 0",
                     bus.idle, bus.credit_cnt, bus.in_ready, bus.out_data_valid, bus.out_data);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step;
            if (bus.out_data_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("FAIL mid_no_output: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_arbitration;
        logic [1:0]  exp_ch [6];
        logic [31:0] exp_d [6];
        logic [1:0]  got_ch [8];
        logic [31:0] got_d [8];
        int n;
`ifdef NI_TX_PRIORITY_EN
        exp_ch = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        exp_d  = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
`else
        exp_ch = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        exp_d  = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
`endif
        do_reset;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_data_valid === 1'b1) begin
                if (n < 8) begin
                    got_ch[n] = bus.out_ch;
                    got_d[n] = bus.out_data;
                end
                n++;
            end
            bus.downstream_credit = bus.out_data_valid;
            if (c < 3) begin
                bus.in_valid = 3'b011;
                bus.in_data = {32'h0, 32'hB0 + 32'(c), 32'hA0 + 32'(c)};
            end else begin
                bus.in_valid = '0;
            end
            step;
        end
        bus.downstream_credit = 1'b0;
        bus.in_valid = '0;
        tests_run++;
        if (n != 6) begin tests_failed++; $display("FAIL arb_count: got %0d expected 6", n); end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (n > k && (got_ch[k] !== exp_ch[k] || got_d[k] !== exp_d[k])) begin
                tests_failed++;
                $display("FAIL arb_order%0d: got ch %0d data %h expected ch %0d data %h", k, got_ch[k], got_d[k], exp_ch[k], exp_d[k]);
            end
        end
        tests_run++;
        if (bus.idle !== 1'b1 || bus.credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL arb_end: got idle %b err %b expected 1 0", bus.idle, bus.credit_err);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.downstream_credit = 1'b0;
        test_reset;
        test_single_push;
        test_back_to_back;
        test_fifo_full;
        test_credit_corner;
        test_reset_mid;
        test_arbitration;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ni_credit_tx.md
Name: ni_credit_tx

Overview:
- Parametrised, multi-channel transmit stage of the PE network interface.
- Merges NUM_CH independent PE-side sources into the single local port of the leaf router. Typical sources: activation send, register-file read response, completion notice.
- Each source has its own buffer; a round-robin arbiter selects one, and a credit counter enforces downstream buffer space.
- Generalises the single-source, single-credit NI output path to N channels, configurable buffer depth and configurable credit depth.

Parameters:
- NUM_CH, 3: number of source channels (2..8).
- DATA_W, 32: flit width in bits.
- FIFO_DEPTH, 4: entries per channel buffer; power of two, at least 2.
- CREDIT_INIT, 4: downstream buffer slots; credit counter reset value.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, NUM_CH: per-channel push request.
- in_data, input, NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready, output, NUM_CH: per-channel buffer not full.
- out_data_valid, output, 1: flit valid to router, one-cycle pulse per flit.
- out_data, output, DATA_W: flit to router.
- out_ch, output, clog2(NUM_CH): source channel of the current flit.
- downstream_credit, input, 1: one-cycle pulse returning one slot.
- router_rdy, output, 1: credit_cnt != 0.
- credit_cnt, output, clog2(CREDIT_INIT+1): current credits.
- idle, output, 1: all buffers empty, no flit in the output register, and credit_cnt == CREDIT_INIT.
- credit_err, output, 1: sticky flag for a credit overflow.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - all buffers empty; in_ready all 1;
  - out_data_valid 0, out_data 0, out_ch 0;
  - credit_cnt = CREDIT_INIT; router_rdy 1;
  - credit_err 0; idle 1;
  - round-robin pointer 0.
- Reset mid-operation discards buffered flits. Credits are restored to CREDIT_INIT with no handshake; the router is reset by the same rst.
- Push:
  - When in_valid[i] && in_ready[i], the flit is written at the tail of buffer i on the clock edge.
  - in_ready[i] = !full[i], purely a function of occupancy.
  - A push into a full buffer is ignored; the bench flags it as a protocol error.
- Arbitration (combinational, cycle t):
  - eligible[i] = buffer i non-empty.
  - Grant fires when any channel is eligible and credit_cnt > 0.
  - Search starts at pointer p and wraps modulo NUM_CH; the first eligible channel wins.
- On a grant to channel g:
  - pop the head of buffer g;
  - register out_data_valid=1, out_data=head, out_ch=g at edge t+1;
  - pointer becomes (g+1) mod NUM_CH;
  - credit decrements.
- With no grant, out_data_valid=0 next cycle; out_data and out_ch hold their last values.
- Latency: a push accepted at edge t is eligible in cycle t+1 and appears on the output at edge t+2 at the earliest (2 cycles).
- Throughput: 1 flit per cycle while credits last.
- A push and a pop on the same buffer in the same cycle are both performed. A full buffer does not raise in_ready in that cycle.
- Credit counter:
  - Grant only: -1.
  - downstream_credit only: +1.
  - Both in the same cycle: unchanged.
  - When credit_cnt == 0 and downstream_credit arrives, a grant is allowed in the next cycle, not the same cycle.
  - Increment at CREDIT_INIT with no grant: counter saturates and credit_err is set until rst.
- Pointer wrap: the wrap from NUM_CH-1 to 0 is exercised for non-power-of-two NUM_CH.

Optional Feature:
- Macro: NI_TX_PRIORITY_EN.
- Defined: channel 0 has strict priority. If buffer 0 is non-empty and credit_cnt > 0, channel 0 is granted. The round-robin pointer is neither consulted nor advanced for channel-0 grants. Channels 1..NUM_CH-1 round-robin among themselves.
- Undefined: plain round-robin across all channels, as above.

Decomposition:
- Shared package ni_pkg (or header): default DATA_W and FIFO_DEPTH; channel index constants (e.g. NI_CH_ACT=0, NI_CH_READ=1, NI_CH_FIN=2); a clog2 helper function.
- One sub-module, ni_tx_fifo:
  - synchronous FIFO, parametrised in DATA_W and FIFO_DEPTH;
  - ports: push, pop, din, dout (head, combinational), full, empty;
  - instantiated NUM_CH times with a generate loop.
- Arbiter and credit logic live in the top module.

Test Plan:
1. Reset, then a single push on ch1 with data 0x0000_00A5 at cycle 3 -> out_data_valid at cycle 5, out_data=0x0000_00A5, out_ch=1, credit_cnt 4->3.
2. All 3 channels push 2 flits each back-to-back, no credits returned -> 4 flits out in order ch0,ch1,ch2,ch0. Then stall with router_rdy=0 and credit_cnt=0. One downstream_credit pulse -> exactly one more flit (ch1) in the following cycle.
3. Fill ch2 with 4 flits and no grants (credit drained) -> in_ready[2]=0; a 5th push is ignored. After credits return, exactly 4 flits emerge in FIFO order.
4. Grant and downstream_credit in the same cycle with credit_cnt=2 -> credit_cnt stays 2. Credit pulse while credit_cnt=4 and idle -> credit_cnt=4, credit_err=1 and sticky.
5. rst asserted for 1 cycle with 3 flits buffered and credit_cnt=1 -> next cycle: idle=1, credit_cnt=4, in_ready=3'b111, no further out_data_valid.
6. With NI_TX_PRIORITY_EN, ch0 and ch1 continuously non-empty and ample credit -> only ch0 flits until ch0 drains, then ch1; without the macro, ch0 and ch1 alternate.
